// File: rtl/escalonador_torneio_if.sv
// Control/result bus of the tournament scheduler.
// The master side presents START and the match results; the slave side is the scheduler.
interface escalonador_torneio_if;
  logic       START;
  logic       RES_VALID;
  logic [1:0] RES;
  logic       BUSY;
  logic       MATCH_REQ;
  logic [2:0] MATCH_IDX;
  logic [3:0] HOME;
  logic [3:0] AWAY;
  logic [3:0] PTS_A;
  logic [3:0] PTS_B;
  logic [3:0] PTS_C;
  logic [3:0] PTS_D;
  logic [3:0] V1;
  logic [3:0] V2;
  logic       DONE;
  logic       ERR;

  modport master (
    output START, RES_VALID, RES,
    input  BUSY, MATCH_REQ, MATCH_IDX, HOME, AWAY,
    input  PTS_A, PTS_B, PTS_C, PTS_D, V1, V2, DONE, ERR
  );

  modport slave (
    input  START, RES_VALID, RES,
    output BUSY, MATCH_REQ, MATCH_IDX, HOME, AWAY,
    output PTS_A, PTS_B, PTS_C, PTS_D, V1, V2, DONE, ERR
  );
endinterface

// File: rtl/escalonador_torneio.sv
// Four-team round-robin scheduler: sequences six matches, accumulates league
// points and ranks first/second place (ties go to the lower-indexed team).
module escalonador_torneio #(
  parameter int unsigned WIN_PTS  = 3,
  parameter int unsigned DRAW_PTS = 1
) (
  input logic                   CLK,
  input logic                   RST,
  escalonador_torneio_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RANK, ST_DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  pts [4];
  logic [2:0]  idx;
  logic [1:0]  rank_i;
  logic [1:0]  best, second, best_n, second_n;
  logic        sec_vld, sec_vld_n;
  logic        err;
  logic [3:0]  v1, v2;
  logic        accept, invalid;
  logic [1:0]  h_i, a_i;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    invalid = 1'b0;
    case (state)
      ST_IDLE: if (bus.START) state_n = ST_WAIT;
      ST_WAIT: begin
        if (bus.RES_VALID) begin
          if (bus.RES == 2'b11) begin
            invalid = 1'b1;
          end else begin
            accept = 1'b1;
            if (idx == 3'd5) state_n = ST_RANK;
          end
        end
      end
      ST_RANK: if (rank_i == 2'd3) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Fixed pairing order: A-B, A-C, A-D, B-C, B-D, C-D
  always_comb begin
    h_i = 2'd0;
    a_i = 2'd1;
    case (idx)
      3'd1: a_i = 2'd2;
      3'd2: a_i = 2'd3;
      3'd3: begin h_i = 2'd1; a_i = 2'd2; end
      3'd4: begin h_i = 2'd1; a_i = 2'd3; end
      3'd5: begin h_i = 2'd2; a_i = 2'd3; end
      default: ;
    endcase
  end

  // One team per RANK cycle; strict compares keep the earlier team on ties
  always_comb begin
    best_n    = best;
    second_n  = second;
    sec_vld_n = sec_vld;
    if (rank_i == 2'd0) begin
      best_n    = 2'd0;
      sec_vld_n = 1'b0;
    end else if (pts[rank_i] > pts[best]) begin
      second_n  = best;
      sec_vld_n = 1'b1;
      best_n    = rank_i;
    end else if (!sec_vld || (pts[rank_i] > pts[second])) begin
      second_n  = rank_i;
      sec_vld_n = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      for (int unsigned t = 0; t < 4; t++) pts[t] <= '0;
      idx     <= '0;
      rank_i  <= '0;
      best    <= '0;
      second  <= '0;
      sec_vld <= 1'b0;
      err     <= 1'b0;
      v1      <= '0;
      v2      <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            for (int unsigned t = 0; t < 4; t++) pts[t] <= '0;
            err    <= 1'b0;
            idx    <= '0;
            rank_i <= '0;
          end
        end
        ST_WAIT: begin
          if (invalid) err <= 1'b1;
          if (accept) begin
            case (bus.RES)
              2'b00: pts[h_i] <= pts[h_i] + 4'(WIN_PTS);
              2'b10: pts[a_i] <= pts[a_i] + 4'(WIN_PTS);
              default: begin
                pts[h_i] <= pts[h_i] + 4'(DRAW_PTS);
                pts[a_i] <= pts[a_i] + 4'(DRAW_PTS);
              end
            endcase
            if (idx != 3'd5) idx <= idx + 3'd1;
          end
        end
        ST_RANK: begin
          best    <= best_n;
          second  <= second_n;
          sec_vld <= sec_vld_n;
          rank_i  <= rank_i + 2'd1;
          if (rank_i == 2'd3) begin
            v1 <= 4'b0001 << best_n;
            v2 <= 4'b0001 << second_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY      = (state == ST_WAIT) || (state == ST_RANK);
  assign bus.MATCH_REQ = (state == ST_WAIT);
  assign bus.MATCH_IDX = idx;
  assign bus.HOME      = (state == ST_WAIT) ? (4'b0001 << h_i) : '0;
  assign bus.AWAY      = (state == ST_WAIT) ? (4'b0001 << a_i) : '0;
  assign bus.PTS_A     = pts[0];
  assign bus.PTS_B     = pts[1];
  assign bus.PTS_C     = pts[2];
  assign bus.PTS_D     = pts[3];
  assign bus.V1        = v1;
  assign bus.V2        = v2;
  assign bus.DONE      = (state == ST_DONE);
  assign bus.ERR       = err;

endmodule

// File: tb/tb_escalonador_torneio.sv
// Directed bench for escalonador_torneio; expected rankings are queued when
// the last result of a tournament is driven and popped when DONE appears.
module tb_escalonador_torneio;

  localparam int WIN  = 3;
  localparam int DRAW = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  escalonador_torneio_if bus ();

  escalonador_torneio #(.WIN_PTS(WIN), .DRAW_PTS(DRAW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int mp [4];
  int hm [6] = '{0, 0, 0, 1, 1, 2};
  int aw [6] = '{1, 2, 3, 2, 3, 3};
  bit exp_err;
  logic [7:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model_rank();
    logic [3:0] f, s;
    int r;
    f = '0;
    s = '0;
    for (int t = 0; t < 4; t++) begin
      r = 0;
      for (int u = 0; u < 4; u++)
        if (mp[u] > mp[t] || (mp[u] == mp[t] && u < t)) r++;
      if (r == 0) f[t] = 1'b1;
      if (r == 1) s[t] = 1'b1;
    end
    return {f, s};
  endfunction

  task automatic chk_pts(input string tag);
    chk({tag, "_pa"}, 32'(bus.PTS_A), mp[0]);
    chk({tag, "_pb"}, 32'(bus.PTS_B), mp[1]);
    chk({tag, "_pc"}, 32'(bus.PTS_C), mp[2]);
    chk({tag, "_pd"}, 32'(bus.PTS_D), mp[3]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(bus.BUSY), 0);
    chk({tag, "_req"},  32'(bus.MATCH_REQ), 0);
    chk({tag, "_done"}, 32'(bus.DONE), 0);
    chk({tag, "_err"},  32'(bus.ERR), 0);
    chk({tag, "_idx"},  32'(bus.MATCH_IDX), 0);
    chk({tag, "_home"}, 32'(bus.HOME), 0);
    chk({tag, "_away"}, 32'(bus.AWAY), 0);
    chk({tag, "_v1"},   32'(bus.V1), 0);
    chk({tag, "_v2"},   32'(bus.V2), 0);
    for (int t = 0; t < 4; t++) mp[t] = 0;
    chk_pts(tag);
  endtask

  task automatic start_t();
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int t = 0; t < 4; t++) mp[t] = 0;
    exp_err = 1'b0;
    chk("start_busy", 32'(bus.BUSY), 1);
    chk("start_req",  32'(bus.MATCH_REQ), 1);
    chk("start_idx",  32'(bus.MATCH_IDX), 0);
    chk("start_home", 32'(bus.HOME), 32'h1);
    chk("start_away", 32'(bus.AWAY), 32'h2);
    chk("start_err",  32'(bus.ERR), 0);
    chk_pts("start");
  endtask

  task automatic send(input int m, input logic [1:0] r, input int gap, input bit bad, input bit poke);
    for (int g = 0; g < gap; g++) begin
      bus.RES_VALID = 1'b0;
      bus.START     = (poke && g == 1);
      tick();
      bus.START = 1'b0;
      chk("gap_req",  32'(bus.MATCH_REQ), 1);
      chk("gap_idx",  32'(bus.MATCH_IDX), m);
      chk("gap_home", 32'(bus.HOME), 32'(1) << hm[m]);
      chk("gap_away", 32'(bus.AWAY), 32'(1) << aw[m]);
    end
    if (gap > 0) chk_pts("gap");
    if (bad) begin
      bus.RES_VALID = 1'b1;
      bus.RES       = 2'b11;
      tick();
      exp_err = 1'b1;
      chk("bad_err", 32'(bus.ERR), 1);
      chk("bad_idx", 32'(bus.MATCH_IDX), m);
      chk_pts("bad");
    end
    chk("m_idx",  32'(bus.MATCH_IDX), m);
    chk("m_home", 32'(bus.HOME), 32'(1) << hm[m]);
    chk("m_away", 32'(bus.AWAY), 32'(1) << aw[m]);
    bus.RES_VALID = 1'b1;
    bus.RES       = r;
    tick();
    bus.RES_VALID = 1'b0;
    case (r)
      2'b00: mp[hm[m]] += WIN;
      2'b10: mp[aw[m]] += WIN;
      default: begin
        mp[hm[m]] += DRAW;
        mp[aw[m]] += DRAW;
      end
    endcase
    chk_pts("acc");
    if (m < 5) chk("acc_idx", 32'(bus.MATCH_IDX), m + 1);
  endtask

  task automatic finish_t();
    int cyc;
    logic [7:0] e;
    chk("rank_req",  32'(bus.MATCH_REQ), 0);
    chk("rank_busy", 32'(bus.BUSY), 1);
    chk("rank_home", 32'(bus.HOME), 0);
    sb_q.push_back(model_rank());
    cyc = 1;
    while (bus.DONE !== 1'b1 && cyc < 12) begin
      tick();
      cyc++;
    end
    chk("done_seen", 32'(bus.DONE), 1);
    chk("done_lat", cyc, 5);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("v1", 32'(bus.V1), 32'(e[7:4]));
      chk("v2", 32'(bus.V2), 32'(e[3:0]));
    end else begin
      chk("sb_empty", 32'(sb_q.size()), 1);
    end
    chk("done_busy", 32'(bus.BUSY), 0);
    chk("done_err",  32'(bus.ERR), 32'(exp_err));
    tick();
    chk("post_done", 32'(bus.DONE), 0);
    chk("post_busy", 32'(bus.BUSY), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.START = 1'b0;
    bus.RES_VALID = 1'b0;
    bus.RES = 2'b00;
    tick();
    tick();
    chk_reset_vals("rst0");
    rst = 1'b0;
    tick();

    // all home wins, back-to-back
    start_t();
    for (int m = 0; m < 6; m++) send(m, 2'b00, 0, 1'b0, 1'b0);
    chk("hw_pa", 32'(bus.PTS_A), 9);
    chk("hw_pb", 32'(bus.PTS_B), 6);
    chk("hw_pc", 32'(bus.PTS_C), 3);
    chk("hw_pd", 32'(bus.PTS_D), 0);
    finish_t();
    chk("hw_v1", 32'(bus.V1), 32'h1);
    chk("hw_v2", 32'(bus.V2), 32'h2);

    // all away wins
    start_t();
    for (int m = 0; m < 6; m++) send(m, 2'b10, 0, 1'b0, 1'b0);
    finish_t();
    chk("aw_v1", 32'(bus.V1), 32'h8);
    chk("aw_v2", 32'(bus.V2), 32'h4);
    chk("aw_pd", 32'(bus.PTS_D), 9);

    // all draws: tie-break towards A then B
    start_t();
    for (int m = 0; m < 6; m++) send(m, 2'b01, 0, 1'b0, 1'b0);
    chk("dr_pc", 32'(bus.PTS_C), 3);
    finish_t();
    chk("dr_v1", 32'(bus.V1), 32'h1);
    chk("dr_v2", 32'(bus.V2), 32'h2);

    // invalid code on match 2
    start_t();
    send(0, 2'b00, 0, 1'b0, 1'b0);
    send(1, 2'b10, 0, 1'b0, 1'b0);
    send(2, 2'b00, 0, 1'b1, 1'b0);
    send(3, 2'b10, 0, 1'b0, 1'b0);
    send(4, 2'b01, 0, 1'b0, 1'b0);
    chk("inv_err_hold", 32'(bus.ERR), 1);
    send(5, 2'b00, 0, 1'b0, 1'b0);
    finish_t();

    // gaps between results, START pulsed while busy
    start_t();
    send(0, 2'b01, 3, 1'b0, 1'b0);
    send(1, 2'b00, 3, 1'b0, 1'b0);
    send(2, 2'b10, 3, 1'b0, 1'b0);
    send(3, 2'b10, 3, 1'b0, 1'b1);
    send(4, 2'b00, 3, 1'b0, 1'b0);
    send(5, 2'b01, 3, 1'b0, 1'b0);
    finish_t();

    // reset after match 3 accepted, then replay
    start_t();
    send(0, 2'b00, 0, 1'b0, 1'b0);
    send(1, 2'b10, 0, 1'b0, 1'b0);
    send(2, 2'b01, 0, 1'b1, 1'b0);
    send(3, 2'b00, 0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset_vals("rst1");
    rst = 1'b0;
    tick();
    start_t();
    send(0, 2'b10, 0, 1'b0, 1'b0);
    send(1, 2'b10, 0, 1'b0, 1'b0);
    send(2, 2'b00, 0, 1'b0, 1'b0);
    send(3, 2'b01, 0, 1'b0, 1'b0);
    send(4, 2'b00, 0, 1'b0, 1'b0);
    send(5, 2'b10, 0, 1'b0, 1'b0);
    finish_t();

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
